// File: rtl/gate_test_seq_if.sv
// Signal bundle between the gate test sequencer and its environment (stimulus side
// plus the device under control).
interface gate_test_seq_if;
    logic       start;
    logic       abort;
    logic [7:0] exp;
    logic       d_out;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] mismatch;

    // Environment side: requests sweeps and reflects the gate output back.
    modport master (
        output start, abort, exp, d_out,
        input  a, b, c, busy, done, result, mismatch
    );

    // Sequencer side.
    modport slave (
        input  start, abort, exp, d_out,
        output a, b, c, busy, done, result, mismatch
    );
endinterface

// File: rtl/gate_test_seq.sv
// Exhaustive 3-input gate tester: walks all 8 input vectors, holds each for a settle
// time, captures the gate output and compares the captured pattern against exp.
module gate_test_seq #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic              clock,
    input logic              reset_n,
    gate_test_seq_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StApply, StSettle, StSample, StDone} state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q;
    logic [3:0] cnt_q;
    logic [2:0] abc_q;
    logic [7:0] result_q;
    logic [7:0] mismatch_q;
    logic       accept;

    assign accept = bus.start && !bus.abort;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StApply;
            StApply:  state_d = bus.abort ? StIdle : StSettle;
            StSettle: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (idx_q == 3'd7) begin
                    state_d = StDone;
                end else begin
                    state_d = StApply;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Vector drives only change on the edge that enters StApply; an abort leaves them held.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx_q      <= 3'd0;
            cnt_q      <= 4'd0;
            abc_q      <= 3'd0;
            result_q   <= 8'd0;
            mismatch_q <= 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        idx_q      <= 3'd0;
                        abc_q      <= 3'd0;
                        result_q   <= 8'd0;
                        mismatch_q <= 8'd0;
                    end
                end
                StApply: begin
                    if (!bus.abort) cnt_q <= SettleLoad;
                end
                StSettle: begin
                    if (!bus.abort && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                StSample: begin
                    if (!bus.abort) begin
                        result_q[idx_q] <= bus.d_out;
                        if (idx_q != 3'd7) begin
                            idx_q <= idx_q + 3'd1;
                            abc_q <= idx_q + 3'd1;
                        end
                    end
                end
                StDone: begin
                    mismatch_q <= result_q ^ bus.exp;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy     = (state_q != StIdle);
        bus.done     = (state_q == StDone);
        bus.a        = abc_q[2];
        bus.b        = abc_q[1];
        bus.c        = abc_q[0];
        bus.result   = result_q;
        bus.mismatch = mismatch_q;
    end

endmodule

// File: tb/tb_gate_test_seq.sv
// Directed bench for gate_test_seq driving a zero-delay (A&B)|C gate; expected capture
// patterns are queued at stimulus time and popped when the sweep reports completion.
module tb_gate_test_seq;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] mis;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    gate_test_seq_if bus ();

    gate_test_seq #(.SETTLE_CYCLES(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.d_out = (bus.a & bus.b) | bus.c;

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Independent gate model: capture pattern for vectors 0..7.
    function automatic logic [7:0] gate_pattern();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v    = 3'(i);
            r[i] = (v[2] & v[1]) | v[0];
        end
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_abc"}, {29'd0, bus.a, bus.b, bus.c}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_result"}, {24'd0, bus.result}, 32'd0);
        check({tag, "_mismatch"}, {24'd0, bus.mismatch}, 32'd0);
    endtask

    // Start pulse in the current cycle (cycle 0), then follow the sweep to cycle 50.
    // disturb re-pulses start in cycles 10 and 49 and raises abort in the DONE cycle.
    task automatic sweep(input logic [7:0] e, input bit disturb);
        logic [7:0] r;
        exp_t       x;
        r       = gate_pattern();
        bus.exp = e;
        sb.push_back({r, r ^ e});
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            int v;
            v = (cyc - 1) / 6;
            if (v > 7) v = 7;
            if (cyc <= 49) begin
                check("abc", {29'd0, bus.a, bus.b, bus.c}, 32'(v));
                check("busy_run", {31'd0, bus.busy}, 32'd1);
            end
            check("done", {31'd0, bus.done}, (cyc == 49) ? 32'd1 : 32'd0);
            if (cyc == 50) begin
                check("busy_end", {31'd0, bus.busy}, 32'd0);
                x = sb.pop_front();
                check("result", {24'd0, bus.result}, {24'd0, x.res});
                check("mismatch", {24'd0, bus.mismatch}, {24'd0, x.mis});
            end else begin
                if (disturb && (cyc == 10 || cyc == 49)) bus.start = 1'b1;
                if (disturb && cyc == 49) bus.abort = 1'b1;
                step();
                bus.start = 1'b0;
                bus.abort = 1'b0;
            end
        end
    endtask

    initial begin
        exp_t x;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.exp   = 8'hEA;
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Full sweep, first start right after reset release.
        sweep(8'hEA, 1'b0);

        // Results hold in IDLE.
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_result", {24'd0, bus.result}, 32'hEA);
            check("hold_busy", {31'd0, bus.busy}, 32'd0);
        end

        // Ignored start while busy, abort in DONE ignored.
        sweep(8'hEA, 1'b1);

        // Mismatch on vector 0.
        sweep(8'hEB, 1'b0);

        // Abort during vector 3 settle.
        bus.exp = 8'hEA;
        sb.push_back({8'h02, 8'h00});
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) step();
        check("abort_abc_before", {29'd0, bus.a, bus.b, bus.c}, 32'd3);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_abc_held", {29'd0, bus.a, bus.b, bus.c}, 32'd3);
        x = sb.pop_front();
        check("abort_result", {24'd0, bus.result}, {24'd0, x.res});
        check("abort_mismatch", {24'd0, bus.mismatch}, {24'd0, x.mis});
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_done", {31'd0, bus.done}, 32'd0);
            check("abort_idle", {31'd0, bus.busy}, 32'd0);
        end

        // start and abort together in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("collide_busy", {31'd0, bus.busy}, 32'd0);
        step();
        check("collide_busy2", {31'd0, bus.busy}, 32'd0);
        check("collide_result", {24'd0, bus.result}, 32'h02);

        // Reset mid-sweep, then a clean sweep started on the first edge after release.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 30; cyc++) step();
        check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        step();
        check_all_zero("midreset");
        reset_n = 1'b1;
        sweep(8'hEA, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_test_seq.md
GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, number of clock cycles each vector is held before OUT is sampled; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to run one full 8-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminates a sweep in progress.
REQ-006 exp  input  8  expected OUT per vector, bit i = expected OUT for vector i; sampled in DONE.
REQ-007 d_out  input  1  OUT of the module D instance under control.
REQ-008 a, b, c  output  1 each  registered drives to D inputs A, B, C.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 result  output  8  captured OUT per vector, bit i = vector i.
REQ-012 mismatch  output  8  result XOR exp, latched at completion.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-014 The 3-bit vector index idx SHALL drive {a,b,c} = idx (a = MSB); the drives SHALL update only on entry to APPLY.
REQ-015 IDLE: start=1 and abort=0 -> APPLY with idx=0; result and mismatch cleared on the same edge.
REQ-016 APPLY SHALL last exactly 1 cycle, then -> SETTLE with the settle counter loaded.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-018 SAMPLE SHALL last 1 cycle and write result[idx] <= d_out.
REQ-019 SAMPLE with idx<7 -> APPLY with idx+1; SAMPLE with idx==7 -> DONE (no wrap to 0).
REQ-020 DONE SHALL last 1 cycle with done=1 and mismatch <= result XOR exp, then -> IDLE.
REQ-021 Per-vector time SHALL be SETTLE_CYCLES+2 cycles; done SHALL be high in cycle 8*(SETTLE_CYCLES+2)+1 after the cycle start was sampled.
REQ-022 start while busy=1 SHALL be ignored, with no restart and no queueing.
REQ-023 abort=1 in APPLY, SETTLE or SAMPLE SHALL -> IDLE next edge, with no done pulse, no result write that cycle, a/b/c held, and partial result retained.
REQ-024 abort=1 in DONE SHALL be ignored (the sweep completes normally).
REQ-025 In IDLE with start=1 and abort=1 together, abort SHALL win and the FSM stays IDLE.
REQ-026 result and mismatch SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force: state IDLE, idx 0, a=b=c=0, busy=0, done=0, result=0, mismatch=0.
REQ-028 Reset SHALL take priority over start and abort in every state, including mid-sweep; no done pulse on exit.
REQ-029 After reset_n returns to 1, a start SHALL be accepted on the first rising edge.

Verification (SETTLE_CYCLES=4; zero-delay D model, OUT=(A&B)|C; exp=8'hEA unless stated)
REQ-030 Full sweep:
- start pulse in cycle 0 -> {a,b,c} steps 000..111, each held 6 cycles.
- done=1 only in cycle 49; result=8'hEA, mismatch=8'h00, busy falls in cycle 50.
REQ-031 Mismatch: exp=8'hEB, full sweep -> result=8'hEA, mismatch=8'h01.
REQ-032 Abort: abort in cycle 20 (vector 3, SETTLE) -> busy=0 from cycle 21, no done, result=8'h02 (vectors 0..2 captured).
REQ-033 Reset mid-sweep: reset_n=0 in cycle 30 -> next cycle all outputs 0; start in the next cycle runs a clean full sweep with done at +49.
REQ-034 Ignored start and collision:
- start re-pulsed in cycles 10 and 49 -> no effect on timing or result.
- start+abort together in IDLE -> busy stays 0.
